axi_wdata_fifo: RTL and testbench



---
 rtl/axi_wdata_fifo_if.sv | 34 +++
 rtl/axi_wdata_fifo.sv | 146 ++++++++++++++
 tb/tb_axi_wdata_fifo.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wdata_fifo_if.sv
// Handshake bundle for the AXI write-data FIFO: W channel in, SDRAM controller pop side, B channel out.
// The slave modport is the FIFO's view; the master modport drives W, ddr_wreq/ddr_wdone/ddr_werr and bready.
interface axi_wdata_fifo_if #(
  parameter int AXI_DATA_WIDTH = 16,
  parameter int STRB_WIDTH     = AXI_DATA_WIDTH / 8
);
  logic                      wvalid;
  logic                      wready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0]     wstrb;
  logic                      wlast;

  logic                      ddr_wvalid;
  logic                      ddr_wreq;
  logic [AXI_DATA_WIDTH-1:0] ddr_wdata;
  logic [STRB_WIDTH-1:0]     ddr_wstrb;
  logic                      ddr_wlast;
  logic                      ddr_wdone;
  logic                      ddr_werr;

  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;

  modport master (
    output wvalid, wdata, wstrb, wlast, ddr_wreq, ddr_wdone, ddr_werr, bready,
    input  wready, ddr_wvalid, ddr_wdata, ddr_wstrb, ddr_wlast, bvalid, bresp
  );

  modport slave (
    input  wvalid, wdata, wstrb, wlast, ddr_wreq, ddr_wdone, ddr_werr, bready,
    output wready, ddr_wvalid, ddr_wdata, ddr_wstrb, ddr_wlast, bvalid, bresp
  );
endinterface

// File: rtl/axi_wdata_fifo.sv
// AXI W-channel buffer: RAM FIFO with prefetching head register, one-burst-outstanding B-response FSM.
// Optional macro WFIFO_LEVEL_EN adds a registered occupancy output 'level'.
module axi_wdata_fifo #(
  parameter int AXI_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int STRB_WIDTH     = AXI_DATA_WIDTH / 8
) (
  input  logic clk,
  input  logic rstn,
  axi_wdata_fifo_if.slave bus
`ifdef WFIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0] level
`endif
);

  localparam int EW    = 1 + STRB_WIDTH + AXI_DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  logic [EW-1:0]         mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;   // next slot to write
  logic [ADDR_WIDTH-1:0] rptr;   // oldest entry not yet taken by the controller
  logic [ADDR_WIDTH-1:0] raddr;  // next entry to prefetch out of the RAM
  logic                  run_q;
  logic [EW-1:0]         rd_data;
  logic                  rd_valid;
  logic [EW-1:0]         head;
  logic                  head_valid;
  state_t                state;
  logic                  fwd_en;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic full, wready_i, ddr_wvalid_i, push, pop, head_load, rd_issue;

  // rptr only moves when the controller pops, so full covers RAM, read stage and head together.
  assign full         = (wptr + PTR_ONE) == rptr;
  assign wready_i     = run_q & ~full;
  assign ddr_wvalid_i = head_valid & fwd_en;
  assign push         = bus.wvalid & wready_i;
  assign pop          = ddr_wvalid_i & bus.ddr_wreq;
  assign head_load    = rd_valid & (~head_valid | pop);
  assign rd_issue     = (raddr != wptr) & (~rd_valid | head_load);

  assign bus.wready     = wready_i;
  assign bus.ddr_wvalid = ddr_wvalid_i;
  assign bus.ddr_wdata  = head[AXI_DATA_WIDTH-1:0];
  assign bus.ddr_wstrb  = head[AXI_DATA_WIDTH +: STRB_WIDTH];
  assign bus.ddr_wlast  = head[EW-1];
  assign bus.bvalid     = bvalid_q;
  assign bus.bresp      = bresp_q;

  // NOTE: storage arrays carry no reset so they map onto plain RAM macros; valid flags guard their contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.wlast, bus.wstrb, bus.wdata};
  end

  // Read address never equals wptr when issuing, so no same-address read/write collision exists.
  always_ff @(posedge clk) begin
    if (rd_issue) rd_data <= mem[raddr];
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      raddr      <= '0;
      run_q      <= 1'b0;
      rd_valid   <= 1'b0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (push)      wptr  <= wptr + PTR_ONE;
      if (pop)       rptr  <= rptr + PTR_ONE;
      if (rd_issue)  raddr <= raddr + PTR_ONE;
      if (head_load) head  <= rd_data;
      rd_valid   <= rd_issue | (rd_valid & ~head_load);
      head_valid <= head_load | (head_valid & ~pop);
    end
  end

  // One burst outstanding: forwarding stops after a last beat until its B handshake completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      fwd_en   <= 1'b1;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop && head[EW-1]) begin
            state  <= S_WAIT_DONE;
            fwd_en <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          if (bus.ddr_wdone) begin
            state    <= S_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= bus.ddr_werr ? 2'b10 : 2'b00;
          end
        end
        S_RESP: begin
          if (bus.bready) begin
            state    <= S_IDLE;
            bvalid_q <= 1'b0;
            fwd_en   <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          fwd_en   <= 1'b1;
          bvalid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef WFIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  logic [ADDR_WIDTH:0] level_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_q <= level_q - LVL_ONE;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_axi_wdata_fifo.sv
// Self-checking bench for axi_wdata_fifo: directed scenarios plus random traffic against a queue-based model.
// Level checks are compiled in when WFIFO_LEVEL_EN is defined.
module tb_axi_wdata_fifo;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int AW  = 10;
  localparam int CAP = 2 ** AW - 1;
  localparam int EW  = 1 + SW + DW;
  localparam int S_IDLE = 0, S_WAIT = 1, S_RESP = 2;

  typedef logic [EW-1:0] entry_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_wdata_fifo_if #(.AXI_DATA_WIDTH(DW)) bus_if ();
`ifdef WFIFO_LEVEL_EN
  logic [AW:0] level;
`endif

  axi_wdata_fifo #(.AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
`ifdef WFIFO_LEVEL_EN
    ,
    .level(level)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: ordered queue of accepted beats plus the one-burst-outstanding response rule.
  entry_t     q[$];
  int         pop_cycles[$];
  int         m_state;
  int         m_count;
  logic [1:0] m_bresp;
  logic       prev_hold;
  entry_t     prev_head;

  task automatic idle_inputs();
    bus_if.wvalid    = 1'b0;
    bus_if.wdata     = '0;
    bus_if.wstrb     = '0;
    bus_if.wlast     = 1'b0;
    bus_if.ddr_wreq  = 1'b0;
    bus_if.ddr_wdone = 1'b0;
    bus_if.ddr_werr  = 1'b0;
    bus_if.bready    = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    pop_cycles.delete();
    m_state   = S_IDLE;
    m_count   = 0;
    m_bresp   = 2'b00;
    prev_hold = 1'b0;
    prev_head = '0;
  endtask

  // One clock: compare DUT against model mid-cycle, advance model by the coming edge, then step past it.
  task automatic tick();
    logic   exp_wready, push, pop, popped_last;
    entry_t cur, e;
    int     nxt;
    @(negedge clk);
    cycle++;
    exp_wready = (m_count < CAP);
    cur = {bus_if.ddr_wlast, bus_if.ddr_wstrb, bus_if.ddr_wdata};
    checks++;
    if (bus_if.wready !== exp_wready) begin
      errors++;
      $display("FAIL wready @%0d: got %b expected %b", cycle, bus_if.wready, exp_wready);
    end
`ifdef WFIFO_LEVEL_EN
    checks++;
    if (int'(level) != m_count) begin
      errors++;
      $display("FAIL level @%0d: got %0d expected %0d", cycle, level, m_count);
    end
`endif
    if (m_state != S_IDLE || q.size() == 0) begin
      checks++;
      if (bus_if.ddr_wvalid !== 1'b0) begin
        errors++;
        $display("FAIL ddr_wvalid_blocked @%0d: got %b expected 0", cycle, bus_if.ddr_wvalid);
      end
    end
    checks++;
    if (bus_if.bvalid !== (m_state == S_RESP)) begin
      errors++;
      $display("FAIL bvalid @%0d: got %b expected %b", cycle, bus_if.bvalid, m_state == S_RESP);
    end
    if (m_state == S_RESP) begin
      checks++;
      if (bus_if.bresp !== m_bresp) begin
        errors++;
        $display("FAIL bresp @%0d: got %b expected %b", cycle, bus_if.bresp, m_bresp);
      end
    end
    if (prev_hold && bus_if.ddr_wvalid) begin
      checks++;
      if (cur !== prev_head) begin
        errors++;
        $display("FAIL head_stable @%0d: got %h expected %h", cycle, cur, prev_head);
      end
    end
    prev_hold = bus_if.ddr_wvalid & ~bus_if.ddr_wreq;
    prev_head = cur;

    push = bus_if.wvalid & exp_wready;
    pop  = bus_if.ddr_wvalid & bus_if.ddr_wreq;
    popped_last = 1'b0;
    if (pop && q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (cur !== e) begin
        errors++;
        $display("FAIL pop_data @%0d: got %h expected %h", cycle, cur, e);
      end
      popped_last = e[EW-1];
      pop_cycles.push_back(cycle);
    end
    if (push) q.push_back({bus_if.wlast, bus_if.wstrb, bus_if.wdata});
    m_count = q.size();

    nxt = m_state;
    case (m_state)
      S_IDLE: if (popped_last) nxt = S_WAIT;
      S_WAIT: if (bus_if.ddr_wdone) begin
        nxt = S_RESP;
        m_bresp = bus_if.ddr_werr ? 2'b10 : 2'b00;
      end
      S_RESP: if (bus_if.bready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    m_state = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pop_cycles.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (pop_cycles.size() < n) begin
      errors++;
      $display("FAIL pop_timeout: got %0d pops expected %0d", pop_cycles.size(), n);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_if.wready, bus_if.ddr_wvalid, bus_if.bvalid, bus_if.bresp} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: got wready=%b ddr_wvalid=%b bvalid=%b bresp=%b expected all 0",
               bus_if.wready, bus_if.ddr_wvalid, bus_if.bvalid, bus_if.bresp);
    end
    model_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.wready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wready: got %b expected 1", bus_if.wready);
    end
    checks++;
    if ({bus_if.ddr_wvalid, bus_if.bvalid, bus_if.bresp, bus_if.ddr_wdata, bus_if.ddr_wstrb, bus_if.ddr_wlast} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ddr_wvalid=%b bvalid=%b bresp=%b wdata=%h expected zeros",
               bus_if.ddr_wvalid, bus_if.bvalid, bus_if.bresp, bus_if.ddr_wdata);
    end
`ifdef WFIFO_LEVEL_EN
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
`endif
    repeat (3) tick();
  endtask

  task automatic test_single();
    do_reset();
    bus_if.ddr_wreq = 1'b1;
    bus_if.wvalid = 1'b1; bus_if.wdata = 16'hA5A5; bus_if.wstrb = 2'b11; bus_if.wlast = 1'b1;
    tick();
    bus_if.wvalid = 1'b0;
    checks++;
    if (bus_if.ddr_wvalid !== 1'b0) begin
      errors++; $display("FAIL single_lat1: got ddr_wvalid=%b expected 0", bus_if.ddr_wvalid);
    end
    tick();
    checks++;
    if (bus_if.ddr_wvalid !== 1'b0) begin
      errors++; $display("FAIL single_lat2: got ddr_wvalid=%b expected 0", bus_if.ddr_wvalid);
    end
    tick();
    checks++;
    if ({bus_if.ddr_wvalid, bus_if.ddr_wdata, bus_if.ddr_wstrb, bus_if.ddr_wlast} !== {1'b1, 16'hA5A5, 2'b11, 1'b1}) begin
      errors++;
      $display("FAIL single_head: got v=%b d=%h s=%b l=%b expected v=1 d=a5a5 s=11 l=1",
               bus_if.ddr_wvalid, bus_if.ddr_wdata, bus_if.ddr_wstrb, bus_if.ddr_wlast);
    end
    tick();
    checks++;
    if ({bus_if.ddr_wvalid, bus_if.bvalid} !== 2'b00) begin
      errors++; $display("FAIL single_after_pop: got ddr_wvalid=%b bvalid=%b expected 0 0", bus_if.ddr_wvalid, bus_if.bvalid);
    end
    bus_if.ddr_wreq = 1'b0;
    bus_if.ddr_wdone = 1'b1;
    tick();
    bus_if.ddr_wdone = 1'b0;
    checks++;
    if ({bus_if.bvalid, bus_if.bresp} !== 3'b100) begin
      errors++; $display("FAIL single_b: got bvalid=%b bresp=%b expected 1 00", bus_if.bvalid, bus_if.bresp);
    end
    repeat (2) tick();
    bus_if.bready = 1'b1;
    tick();
    bus_if.bready = 1'b0;
    checks++;
    if (bus_if.bvalid !== 1'b0) begin
      errors++; $display("FAIL single_b_clear: got bvalid=%b expected 0", bus_if.bvalid);
    end
    tick();
  endtask

  task automatic test_full();
    int k;
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      bus_if.wvalid = 1'b1;
      bus_if.wdata  = DW'(i);
      bus_if.wstrb  = SW'($urandom);
      bus_if.wlast  = 1'b0;
      tick();
    end
    checks++;
    if (bus_if.wready !== 1'b0) begin
      errors++; $display("FAIL full_wready: got %b expected 0", bus_if.wready);
    end
`ifdef WFIFO_LEVEL_EN
    checks++;
    if (int'(level) != CAP) begin
      errors++; $display("FAIL full_level: got %0d expected %0d", level, CAP);
    end
`endif
    bus_if.wdata = DW'(CAP);
    repeat (3) tick();
    bus_if.wvalid = 1'b0;
    bus_if.ddr_wreq = 1'b1;
    tick();
    bus_if.ddr_wreq = 1'b0;
    checks++;
    if (bus_if.wready !== 1'b1) begin
      errors++; $display("FAIL full_reopen: got wready=%b expected 1", bus_if.wready);
    end
`ifdef WFIFO_LEVEL_EN
    checks++;
    if (int'(level) != CAP - 1) begin
      errors++; $display("FAIL full_level_pop: got %0d expected %0d", level, CAP - 1);
    end
`endif
    bus_if.ddr_wreq = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 3 * CAP) begin
      tick();
      k++;
    end
    checks++;
    if (pop_cycles.size() != CAP) begin
      errors++; $display("FAIL full_drain: got %0d pops expected %0d", pop_cycles.size(), CAP);
    end
    repeat (3) tick();
    bus_if.ddr_wreq = 1'b0;
  endtask

  task automatic test_back_to_back();
    int b_cycle;
    do_reset();
    bus_if.ddr_wreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_if.wvalid = 1'b1;
      bus_if.wdata  = DW'(16'h0100 + i);
      bus_if.wstrb  = SW'($urandom);
      bus_if.wlast  = (i == 3 || i == 7);
      tick();
    end
    bus_if.wvalid = 1'b0;
    wait_pops(4, 20);
    if (pop_cycles.size() >= 4) begin
      checks++;
      if (pop_cycles[3] - pop_cycles[0] != 3) begin
        errors++; $display("FAIL b2b_burst1_rate: got span %0d expected 3", pop_cycles[3] - pop_cycles[0]);
      end
    end
    repeat (5) tick();
    checks++;
    if (pop_cycles.size() != 4) begin
      errors++; $display("FAIL b2b_hold: got %0d pops expected 4", pop_cycles.size());
    end
    bus_if.ddr_wdone = 1'b1;
    tick();
    bus_if.ddr_wdone = 1'b0;
    bus_if.bready = 1'b1;
    tick();
    bus_if.bready = 1'b0;
    b_cycle = cycle;
    wait_pops(8, 20);
    if (pop_cycles.size() >= 8) begin
      checks++;
      if (pop_cycles[7] - pop_cycles[4] != 3 || pop_cycles[4] <= b_cycle) begin
        errors++;
        $display("FAIL b2b_burst2: got first=%0d span=%0d expected first>%0d span=3",
                 pop_cycles[4], pop_cycles[7] - pop_cycles[4], b_cycle);
      end
    end
    bus_if.ddr_wdone = 1'b1;
    tick();
    bus_if.ddr_wdone = 1'b0;
    bus_if.bready = 1'b1;
    tick();
    bus_if.bready = 1'b0;
    bus_if.ddr_wreq = 1'b0;
    tick();
  endtask

  task automatic test_slverr();
    do_reset();
    bus_if.ddr_wdone = 1'b1; bus_if.ddr_werr = 1'b1;
    tick();
    bus_if.ddr_wdone = 1'b0; bus_if.ddr_werr = 1'b0;
    checks++;
    if (bus_if.bvalid !== 1'b0) begin
      errors++; $display("FAIL idle_wdone_ignored: got bvalid=%b expected 0", bus_if.bvalid);
    end
    bus_if.ddr_wreq = 1'b1;
    bus_if.wvalid = 1'b1; bus_if.wdata = 16'h5EED; bus_if.wstrb = 2'b01; bus_if.wlast = 1'b1;
    tick();
    bus_if.wvalid = 1'b0;
    wait_pops(1, 10);
    bus_if.ddr_wreq = 1'b0;
    bus_if.ddr_wdone = 1'b1; bus_if.ddr_werr = 1'b1;
    tick();
    bus_if.ddr_wdone = 1'b0; bus_if.ddr_werr = 1'b0;
    checks++;
    if ({bus_if.bvalid, bus_if.bresp} !== 3'b110) begin
      errors++; $display("FAIL slverr_b: got bvalid=%b bresp=%b expected 1 10", bus_if.bvalid, bus_if.bresp);
    end
    bus_if.ddr_wdone = 1'b1;
    tick();
    bus_if.ddr_wdone = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus_if.bvalid, bus_if.bresp} !== 3'b110) begin
      errors++; $display("FAIL slverr_hold: got bvalid=%b bresp=%b expected 1 10", bus_if.bvalid, bus_if.bresp);
    end
    bus_if.bready = 1'b1;
    tick();
    bus_if.bready = 1'b0;
    checks++;
    if (bus_if.bvalid !== 1'b0) begin
      errors++; $display("FAIL slverr_clear: got bvalid=%b expected 0", bus_if.bvalid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_if.ddr_wreq = 1'b1;
    bus_if.wvalid = 1'b1; bus_if.wdata = 16'h1234; bus_if.wstrb = 2'b10; bus_if.wlast = 1'b1;
    tick();
    bus_if.wvalid = 1'b0;
    wait_pops(1, 10);
    bus_if.ddr_wreq = 1'b0;
    bus_if.ddr_wdone = 1'b1;
    tick();
    bus_if.ddr_wdone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_if.wvalid = 1'b1;
      bus_if.wdata  = DW'(16'hBEE0 + i);
      bus_if.wstrb  = 2'b11;
      bus_if.wlast  = (i == 2);
      tick();
    end
    bus_if.wvalid = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus_if.bvalid !== 1'b1 || bus_if.ddr_wdata !== 16'hBEE0) begin
      errors++; $display("FAIL midrst_setup: got bvalid=%b head=%h expected 1 bee0", bus_if.bvalid, bus_if.ddr_wdata);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus_if.wready, bus_if.ddr_wvalid, bus_if.bvalid, bus_if.bresp,
         bus_if.ddr_wdata, bus_if.ddr_wstrb, bus_if.ddr_wlast} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got wready=%b ddr_wvalid=%b bvalid=%b bresp=%b wdata=%h expected zeros",
               bus_if.wready, bus_if.ddr_wvalid, bus_if.bvalid, bus_if.bresp, bus_if.ddr_wdata);
    end
`ifdef WFIFO_LEVEL_EN
    checks++;
    if (level !== '0) begin
      errors++; $display("FAIL midrst_level: got %0d expected 0", level);
    end
`endif
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    bus_if.ddr_wreq = 1'b1;
    bus_if.bready = 1'b1;
    repeat (6) tick();
    checks++;
    if ({bus_if.ddr_wvalid, bus_if.bvalid, bus_if.wready} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_after: got ddr_wvalid=%b bvalid=%b wready=%b expected 0 0 1",
               bus_if.ddr_wvalid, bus_if.bvalid, bus_if.wready);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int k;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus_if.wvalid    = ($urandom % 3) != 0;
      bus_if.wdata     = DW'($urandom);
      bus_if.wstrb     = SW'($urandom);
      bus_if.wlast     = ($urandom % 4) == 0;
      bus_if.ddr_wreq  = ($urandom % 4) != 0;
      bus_if.bready    = ($urandom % 3) == 0;
      bus_if.ddr_wdone = (m_state == S_WAIT) ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
      bus_if.ddr_werr  = 1'($urandom);
      tick();
    end
    bus_if.wvalid   = 1'b0;
    bus_if.ddr_wreq = 1'b1;
    bus_if.bready   = 1'b1;
    k = 0;
    while ((q.size() > 0 || m_state != S_IDLE) && k < 5000) begin
      bus_if.ddr_wdone = (m_state == S_WAIT);
      bus_if.ddr_werr  = 1'($urandom);
      tick();
      k++;
    end
    checks++;
    if (q.size() != 0 || m_state != S_IDLE) begin
      errors++; $display("FAIL random_drain: got %0d beats left state %0d expected 0 idle", q.size(), m_state);
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle_inputs();
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_slverr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
